// File: rtl/dcache_if.sv
// Data-cache request/response bus between the MEM-stage access unit and the D-cache.
interface dcache_if;
  logic        dcache_read;
  logic        dcache_write;
  logic [31:0] dcache_address;
  logic [31:0] dcache_wdata;
  logic [3:0]  dcache_byte_enable;
  logic        dcache_resp;
  logic [31:0] dcache_rdata;

  modport master (
    output dcache_read, dcache_write, dcache_address, dcache_wdata, dcache_byte_enable,
    input  dcache_resp, dcache_rdata
  );

  modport slave (
    input  dcache_read, dcache_write, dcache_address, dcache_wdata, dcache_byte_enable,
    output dcache_resp, dcache_rdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store sequencer: IDLE -> ACCESS -> DONE, with byte-lane steering and load extension.
// Optional misaligned-access trap is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata_out,
  output logic        o_stall,
  output logic        o_misalign,
  dcache_if.master    dcache
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      r_state;
  logic        r_rd, r_wr;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_be;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic        w_mem_op, w_aligned, w_start;

  // 0 = byte, 1 = half, 2 = word (reserved encodings fall through to word)
  function automatic logic [1:0] access_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: access_size = 2'd0;
      3'b001, 3'b101: access_size = 2'd1;
      default:        access_size = 2'd2;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
    case (access_size(f3))
      2'd0:    byte_enables = 4'b0001 << off;
      2'd1:    byte_enables = 4'b0011 << off;
      default: byte_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    case (access_size(f3))
      2'd0:    store_lanes = {4{wd[7:0]}};
      2'd1:    store_lanes = {2{wd[15:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rd);
    logic [31:0]        sh_b, sh_h;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh_b = rd >> {off, 3'b000};
    sh_h = rd >> {off[1], 4'b0000};
    b    = sh_b[7:0];
    h    = sh_h[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b100:  load_extend = {24'd0, b};
      3'b101:  load_extend = {16'd0, h};
      default: load_extend = rd;
    endcase
  endfunction

  assign w_mem_op = i_req_valid && (i_mem_read || i_mem_write);

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    case (access_size(i_funct3))
      2'd0:    w_aligned = 1'b1;
      2'd1:    w_aligned = !i_addr[0];
      default: w_aligned = (i_addr[1:0] == 2'b00);
    endcase
  end
  // Trap is reported combinationally so the pipeline can redirect without stalling
  assign o_misalign = !reset && (r_state == IDLE) && w_mem_op && !w_aligned;
`else
  assign w_aligned  = 1'b1;
  assign o_misalign = 1'b0;
`endif

  assign w_start = w_mem_op && w_aligned;
  assign o_stall = ((r_state == IDLE) && w_start) || (r_state == ACCESS);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= ACCESS;
            r_rd    <= i_mem_read;
            r_wr    <= i_mem_write;
          end
        end
        ACCESS: begin
          if (dcache.dcache_resp) begin
            r_state <= DONE;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            if (r_rd) r_rdata <= load_extend(r_funct3, r_off, dcache.dcache_rdata);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Request payload is captured once and held stable for the whole access
  always_ff @(posedge clk) begin
    if ((r_state == IDLE) && w_start) begin
      r_addr   <= {i_addr[31:2], 2'b00};
      r_off    <= i_addr[1:0];
      r_funct3 <= i_funct3;
      r_be     <= byte_enables(i_funct3, i_addr[1:0]);
      r_wdata  <= store_lanes(i_funct3, i_wdata);
    end
  end

  assign dcache.dcache_read        = r_rd;
  assign dcache.dcache_write       = r_wr;
  assign dcache.dcache_address     = r_addr;
  assign dcache.dcache_wdata       = r_wdata;
  assign dcache.dcache_byte_enable = r_be;
  assign o_rdata_out               = r_rdata;

endmodule

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 SHALL have ports: clk, reset (reset reset, synchronous, active-high; clock clk).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  MEM-stage instruction valid.
REQ-005 mem_read / mem_write  in  1 each  load / store request; never both high.
REQ-006 funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-007 addr  in  32  byte address; wdata  in  32  store data (rs2).
REQ-008 dcache_read / dcache_write  out  1 each  cache request strobes.
REQ-009 dcache_address  out  32  word address, addr[1:0] cleared.
REQ-010 dcache_wdata  out  32; dcache_byte_enable  out  4.
REQ-011 dcache_resp  in  1; dcache_rdata  in  32  response data.
REQ-012 rdata_out  out  32  aligned, extended load data; drives MEM-stage rdata toward writeback.
REQ-013 stall  out  1  high = pipeline registers (incl. MEM/WB) SHALL NOT load.
REQ-014 misalign  out  1  one-cycle misaligned-access flag.

Function
REQ-015 SHALL be FSM IDLE, ACCESS, DONE.
REQ-016 IDLE: req_valid & (mem_read|mem_write) & aligned -> latch addr, funct3, wdata, op; stall=1 same cycle; next ACCESS.
REQ-017 ACCESS: strobe from latched op, held high until dcache_resp; stall=1; latched values drive all dcache outputs.
REQ-018 ACCESS & dcache_resp -> load: rdata_out <= extended data; next DONE; response in the same cycle as entry is legal.
REQ-019 DONE: stall=0, strobes 0, one cycle; next IDLE unconditionally; a request seen in DONE SHALL NOT start.
REQ-020 Latency: request in cycle N, ACCESS from N+1, resp at N+1+k (k>=0), stall low at N+2+k.
REQ-021 Byte enables: b 0001<<addr[1:0]; h 0011<<addr[1:0]; w 1111.
REQ-022 Store data: b replicated 4x, h replicated 2x, w unchanged.
REQ-023 Load extract: byte/half selected by addr[1:0]; b/h sign-extend, bu/hu zero-extend, w unchanged.
REQ-024 funct3 011/110/111 SHALL be treated as word.
REQ-025 Aligned: w needs addr[1:0]=00; h needs addr[0]=0; b always.
REQ-026 rdata_out SHALL hold its value until the next load response; stores SHALL NOT change it.
REQ-027 Non-memory instructions or req_valid=0: stall=0, no strobes.
REQ-028 dcache_resp outside ACCESS SHALL be ignored.

Reset
REQ-029 reset SHALL force IDLE, rdata_out=0, misalign=0, strobes=0, stall=0 on next edge.
REQ-030 Reset in ACCESS SHALL abandon the access; dcache_resp in the reset cycle ignored; no rdata_out update.

Configuration
REQ-031 Macro DMEM_MISALIGN_TRAP_EN.
REQ-032 Defined: misaligned request -> no cache access, misalign=1 that cycle, stall=0, state stays IDLE.
REQ-033 Undefined: misalign tied 0; low address bits ignored for alignment check; access proceeds with byte enables from REQ-021 truncated to 4 bits.

Verification
REQ-034 lw addr 0x100, resp after 3 cycles with 0xDEADBEEF -> dcache_address 0x100, stall high 4 cycles, rdata_out 0xDEADBEEF.
REQ-035 lb addr 0x103, dcache_rdata 0x80FF1234 -> byte_enable n/a, rdata_out 0xFFFFFF80; lbu same -> 0x00000080.
REQ-036 sh addr 0x202 wdata 0x0000ABCD -> dcache_write, byte_enable 1100, dcache_wdata 0xABCDABCD, rdata_out unchanged.
REQ-037 lw addr 0x101 with DMEM_MISALIGN_TRAP_EN -> misalign=1 one cycle, no strobe, stall=0.
REQ-038 reset asserted in ACCESS coincident with dcache_resp -> next cycle IDLE, strobes 0, rdata_out 0.
